control_unit: RTL and testbench

//  Microcoded sequencer directly upstream of data_path: fetches, decodes, executes one instruction at a time.

---
 rtl/edulent_pkg.sv | 78 +++++++
 rtl/control_unit_instr_decoder.sv | 47 ++++
 rtl/control_unit.sv | 172 +++++++++++++++++
 tb/tb_control_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/edulent_pkg.sv
// Shared types for the edulent sequencer: transfer codes, opcodes, FSM states
// and the decoded-instruction record handed from the decoder to the sequencer.
package edulent_pkg;

  typedef enum logic [3:0] {
    XFER_NONE   = 4'h0,
    XFER_MA_PC  = 4'h1,
    XFER_MD_MEM = 4'h2,
    XFER_IR_MD  = 4'h3,
    XFER_MA_MD  = 4'h4,
    XFER_REG_MD = 4'h5,
    XFER_MA_AP  = 4'h6,
    XFER_MA_SP  = 4'h7,
    XFER_MD_REG = 4'h8,
    XFER_MEM_MD = 4'h9,
    XFER_R      = 4'hA,
    XFER_PC_MD  = 4'hB,
    XFER_IN     = 4'hC,
    XFER_OUT    = 4'hD,
    XFER_PC_AP  = 4'hE,
    XFER_MD_PC  = 4'hF
  } xfer_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OPER,
    S_EXEC,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_NOP, C_HLT, C_LOAD, C_LDA_AP, C_STORE, C_PUSH, C_POP,
    C_ALU, C_JUMP, C_CALL, C_RET, C_IN, C_OUT, C_ILL
  } class_e;

  typedef enum logic [1:0] {
    OPER_NONE,
    OPER_IMM,
    OPER_DIRECT
  } oper_e;

  typedef struct packed {
    class_e     cls;
    oper_e      oper_mode;
    logic       alu_to_ap;
    logic       illegal;
  } decode_t;

  // Sequencer state plus microstep; kept as one struct so it is visible as a unit.
  typedef struct packed {
    state_e     state;
    logic [3:0] step;
  } fsm_t;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_HLT     = 8'hFF;
  localparam logic [7:0] OP_LDA_I   = 8'h11;
  localparam logic [7:0] OP_LDAP_I  = 8'h13;
  localparam logic [7:0] OP_LDA_AP  = 8'h14;
  localparam logic [7:0] OP_LDA_D   = 8'h19;
  localparam logic [7:0] OP_LDAP_D  = 8'h1B;
  localparam logic [7:0] OP_POP_AP  = 8'h1E;
  localparam logic [7:0] OP_STA     = 8'h21;
  localparam logic [7:0] OP_STAP    = 8'h23;
  localparam logic [7:0] OP_PUSH_A  = 8'h2C;
  localparam logic [7:0] OP_PUSH_AP = 8'h2E;
  localparam logic [7:0] OP_JMP     = 8'hA1;
  localparam logic [7:0] OP_JZ      = 8'hA5;
  localparam logic [7:0] OP_JC      = 8'hA9;
  localparam logic [7:0] OP_CALL    = 8'hB0;
  localparam logic [7:0] OP_RET     = 8'hC1;
  localparam logic [7:0] OP_IN      = 8'hD0;
  localparam logic [7:0] OP_OUT     = 8'hD1;

  localparam logic [7:0] SP_INIT    = 8'h7F;

endpackage

// File: rtl/control_unit_instr_decoder.sv
// Combinational opcode classifier: instruction class, operand fetch mode,
// ALU accumulator select and the undefined-opcode flag.
module instr_decoder
  import edulent_pkg::*;
(
  input  logic [7:0] i_opcode,
  output decode_t    o_dec
);

  logic [3:0] w_hi;
  logic [3:0] w_lo;

  assign w_hi = i_opcode[7:4];
  assign w_lo = i_opcode[3:0];

  always_comb begin
    o_dec.cls       = C_ILL;
    o_dec.oper_mode = OPER_NONE;
    o_dec.alu_to_ap = 1'b0;
    o_dec.illegal   = 1'b1;
    case (i_opcode)
      OP_NOP:                 begin o_dec.cls = C_NOP;    o_dec.illegal = 1'b0; end
      OP_HLT:                 begin o_dec.cls = C_HLT;    o_dec.illegal = 1'b0; end
      OP_LDA_I, OP_LDAP_I:    begin o_dec.cls = C_LOAD;   o_dec.oper_mode = OPER_IMM;    o_dec.illegal = 1'b0; end
      OP_LDA_D, OP_LDAP_D:    begin o_dec.cls = C_LOAD;   o_dec.oper_mode = OPER_DIRECT; o_dec.illegal = 1'b0; end
      OP_LDA_AP:              begin o_dec.cls = C_LDA_AP; o_dec.illegal = 1'b0; end
      OP_STA, OP_STAP:        begin o_dec.cls = C_STORE;  o_dec.oper_mode = OPER_IMM;    o_dec.illegal = 1'b0; end
      OP_PUSH_A, OP_PUSH_AP:  begin o_dec.cls = C_PUSH;   o_dec.illegal = 1'b0; end
      OP_POP_AP:              begin o_dec.cls = C_POP;    o_dec.illegal = 1'b0; end
      OP_JMP, OP_JZ, OP_JC:   begin o_dec.cls = C_JUMP;   o_dec.oper_mode = OPER_IMM;    o_dec.illegal = 1'b0; end
      OP_CALL:                begin o_dec.cls = C_CALL;   o_dec.illegal = 1'b0; end
      OP_RET:                 begin o_dec.cls = C_RET;    o_dec.illegal = 1'b0; end
      OP_IN:                  begin o_dec.cls = C_IN;     o_dec.illegal = 1'b0; end
      OP_OUT:                 begin o_dec.cls = C_OUT;    o_dec.illegal = 1'b0; end
      default: begin
        // ALU group 3x..9x: NOT (5x) and SHR (9x) are single-byte, the rest take an immediate.
        if (w_hi >= 4'h3 && w_hi <= 4'h9) begin
          o_dec.cls       = C_ALU;
          o_dec.illegal   = 1'b0;
          o_dec.oper_mode = (w_hi == 4'h5 || w_hi == 4'h9) ? OPER_NONE : OPER_IMM;
          o_dec.alu_to_ap = (w_lo == 4'h8) && (w_hi == 4'h3 || w_hi == 4'h4);
        end
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Microcoded fetch/decode/execute sequencer driving the edulent data path.
// MEM_RD_WAIT inserts idle cycles between an MA load and the MD<=mem capture (max 6).
module control_unit
  import edulent_pkg::*;
#(
  parameter int MEM_RD_WAIT = 1
)
(
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [7:0] i_ir,
  output logic [3:0] o_transfer_cmd,
  output logic       o_inc_pc,
  output logic [1:0] o_inc_dec_sp,
  output logic       o_alu_calculate,
  output logic       o_alu_res_to_ap,
  output logic       o_reset_ir,
  output logic       o_halted,
  output logic       o_illegal
);

  localparam int K = MEM_RD_WAIT;
  localparam logic [3:0] ST_K1  = 4'(K + 1);
  localparam logic [3:0] ST_K2  = 4'(K + 2);
  localparam logic [3:0] ST_K3  = 4'(K + 3);
  localparam logic [3:0] ST_K4  = 4'(K + 4);
  localparam logic [3:0] ST_K5  = 4'(K + 5);
  localparam logic [3:0] ST_2K3 = 4'(2 * K + 3);

  fsm_t       r_fsm;
  state_e     w_next_state;
  logic [7:0] r_opcode;
  logic [7:0] w_op;
  decode_t    w_dec;
  logic       w_last;
  xfer_e      w_cmd;
  logic       w_inc_pc;
  logic [1:0] w_sp;
  logic       w_calc;
  logic       w_to_ap;
  logic       w_rir;
  logic       w_ill;

  // In DECODE the opcode is not latched yet, so route i_ir straight to the decoder.
  assign w_op = (r_fsm.state == S_DECODE) ? i_ir : r_opcode;

  instr_decoder u_dec (
    .i_opcode (w_op),
    .o_dec    (w_dec)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_fsm.state <= S_FETCH;
      r_fsm.step  <= 4'd0;
      r_opcode    <= 8'h00;
    end else begin
      r_fsm.state <= w_next_state;
      if (w_next_state != r_fsm.state)
        r_fsm.step <= 4'd0;
      else if (r_fsm.state != S_HALT)
        r_fsm.step <= r_fsm.step + 4'd1;
      if (r_fsm.state == S_DECODE)
        r_opcode <= i_ir;
    end
  end

  always_comb begin
    w_next_state = r_fsm.state;
    case (r_fsm.state)
      S_FETCH:  if (w_last) w_next_state = S_DECODE;
      S_DECODE: w_next_state = (w_dec.oper_mode == OPER_NONE) ? S_EXEC : S_OPER;
      S_OPER:   if (w_last) w_next_state = S_EXEC;
      S_EXEC:   if (w_last) w_next_state = (w_dec.cls == C_HLT) ? S_HALT : S_FETCH;
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    w_cmd    = XFER_NONE;
    w_inc_pc = 1'b0;
    w_sp     = 2'b00;
    w_calc   = 1'b0;
    w_to_ap  = 1'b0;
    w_ill    = 1'b0;
    w_last   = 1'b0;
    case (r_fsm.state)
      S_FETCH: begin
        if (r_fsm.step == 4'd0)       w_cmd = XFER_MA_PC;
        else if (r_fsm.step == ST_K1) begin w_cmd = XFER_MD_MEM; w_inc_pc = 1'b1; end
        else if (r_fsm.step == ST_K2) begin w_cmd = XFER_IR_MD;  w_last = 1'b1; end
      end
      S_OPER: begin
        if (r_fsm.step == 4'd0) w_cmd = XFER_MA_PC;
        else if (r_fsm.step == ST_K1) begin
          w_cmd    = XFER_MD_MEM;
          w_inc_pc = 1'b1;
          w_last   = (w_dec.oper_mode == OPER_IMM);
        end
        else if (r_fsm.step == ST_K2)  w_cmd = XFER_MA_MD;
        else if (r_fsm.step == ST_2K3) begin w_cmd = XFER_MD_MEM; w_last = 1'b1; end
      end
      S_EXEC: begin
        case (w_dec.cls)
          C_LOAD: begin w_cmd = XFER_REG_MD; w_last = 1'b1; end
          C_LDA_AP: begin
            if (r_fsm.step == 4'd0)       w_cmd = XFER_MA_AP;
            else if (r_fsm.step == ST_K1) w_cmd = XFER_MD_MEM;
            else if (r_fsm.step == ST_K2) begin w_cmd = XFER_REG_MD; w_last = 1'b1; end
          end
          C_STORE: begin
            if (r_fsm.step == 4'd0)      w_cmd = XFER_MA_MD;
            else if (r_fsm.step == 4'd1) w_cmd = XFER_MD_REG;
            else if (r_fsm.step == 4'd2) begin w_cmd = XFER_MEM_MD; w_last = 1'b1; end
          end
          C_PUSH: begin
            if (r_fsm.step == 4'd0)      w_cmd = XFER_MA_SP;
            else if (r_fsm.step == 4'd1) w_cmd = XFER_MD_REG;
            else if (r_fsm.step == 4'd2) begin w_cmd = XFER_MEM_MD; w_sp = 2'b10; w_last = 1'b1; end
          end
          C_POP: begin
            if (r_fsm.step == 4'd0)       w_sp = 2'b01;
            else if (r_fsm.step == 4'd1)  w_cmd = XFER_MA_SP;
            else if (r_fsm.step == ST_K2) w_cmd = XFER_MD_MEM;
            else if (r_fsm.step == ST_K3) begin w_cmd = XFER_REG_MD; w_last = 1'b1; end
          end
          C_ALU: begin
            w_to_ap = w_dec.alu_to_ap;
            if (r_fsm.step == 4'd0) w_calc = 1'b1;
            else begin w_cmd = XFER_R; w_last = 1'b1; end
          end
          C_JUMP: begin w_cmd = XFER_PC_MD; w_last = 1'b1; end
          // Return address pushed is the operand address; RET skips it with a trailing inc_pc.
          C_CALL: begin
            if (r_fsm.step == 4'd0)       w_cmd = XFER_MA_SP;
            else if (r_fsm.step == 4'd1)  w_cmd = XFER_MD_PC;
            else if (r_fsm.step == 4'd2)  begin w_cmd = XFER_MEM_MD; w_sp = 2'b10; end
            else if (r_fsm.step == 4'd3)  w_cmd = XFER_MA_PC;
            else if (r_fsm.step == ST_K4) w_cmd = XFER_MD_MEM;
            else if (r_fsm.step == ST_K5) begin w_cmd = XFER_PC_MD; w_last = 1'b1; end
          end
          C_RET: begin
            if (r_fsm.step == 4'd0)       w_sp = 2'b01;
            else if (r_fsm.step == 4'd1)  w_cmd = XFER_MA_SP;
            else if (r_fsm.step == ST_K2) w_cmd = XFER_MD_MEM;
            else if (r_fsm.step == ST_K3) w_cmd = XFER_REG_MD;
            else if (r_fsm.step == ST_K4) w_cmd = XFER_PC_AP;
            else if (r_fsm.step == ST_K5) begin w_inc_pc = 1'b1; w_last = 1'b1; end
          end
          C_IN:  begin w_cmd = XFER_IN;  w_last = 1'b1; end
          C_OUT: begin w_cmd = XFER_OUT; w_last = 1'b1; end
          C_ILL: begin w_ill = 1'b1; w_last = 1'b1; end
          default: w_last = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  assign w_rir = (r_fsm.state == S_EXEC) && w_last;

  assign o_transfer_cmd  = i_rstn ? w_cmd : 4'h0;
  assign o_inc_pc        = i_rstn & w_inc_pc;
  assign o_inc_dec_sp    = i_rstn ? w_sp : 2'b00;
  assign o_alu_calculate = i_rstn & w_calc;
  assign o_alu_res_to_ap = i_rstn & w_to_ap;
  assign o_reset_ir      = i_rstn & w_rir;
  assign o_illegal       = i_rstn & w_ill;
  assign o_halted        = i_rstn & (r_fsm.state == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: the bench plays data_path by driving i_ir and
// checks every cycle's output bundle against hand-written microcode sequences.
module tb_control_unit;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic [7:0] i_ir = 8'h00;
  logic [3:0] o_transfer_cmd;
  logic       o_inc_pc;
  logic [1:0] o_inc_dec_sp;
  logic       o_alu_calculate;
  logic       o_alu_res_to_ap;
  logic       o_reset_ir;
  logic       o_halted;
  logic       o_illegal;

  int n_pass  = 0;
  int n_total = 0;

  logic [11:0] w_obs;

  control_unit #(.MEM_RD_WAIT(1)) dut (
    .i_clk           (i_clk),
    .i_rstn          (i_rstn),
    .i_ir            (i_ir),
    .o_transfer_cmd  (o_transfer_cmd),
    .o_inc_pc        (o_inc_pc),
    .o_inc_dec_sp    (o_inc_dec_sp),
    .o_alu_calculate (o_alu_calculate),
    .o_alu_res_to_ap (o_alu_res_to_ap),
    .o_reset_ir      (o_reset_ir),
    .o_halted        (o_halted),
    .o_illegal       (o_illegal)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  assign w_obs = {o_transfer_cmd, o_inc_pc, o_inc_dec_sp, o_alu_calculate,
                  o_alu_res_to_ap, o_reset_ir, o_halted, o_illegal};

  // Expected bundle: {cmd, inc_pc, sp, calc, to_ap, reset_ir, halted, illegal}
  function automatic logic [11:0] v(input logic [3:0] cmd, input logic pc,
                                    input logic [1:0] sp, input logic calc,
                                    input logic ap, input logic rir,
                                    input logic hlt, input logic ill);
    return {cmd, pc, sp, calc, ap, rir, hlt, ill};
  endfunction

  function automatic logic [11:0] c(input logic [3:0] cmd);
    return v(cmd, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [11:0] cr(input logic [3:0] cmd);
    return v(cmd, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  // scoreboard check
  task automatic check(input string tag, input logic [11:0] exp);
    n_total++;
    assert (w_obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, w_obs, exp);
  endtask

  // driver: one clock cycle, sampled on the falling edge
  task automatic cyc(input string tag, input logic [11:0] exp);
    @(negedge i_clk);
    check(tag, exp);
    @(posedge i_clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [7:0] ir);
    i_ir = ir;
    cyc({tag, ".f0"}, c(4'h1));
    cyc({tag, ".f1"}, c(4'h0));
    cyc({tag, ".f2"}, v(4'h2, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc({tag, ".f3"}, c(4'h3));
    cyc({tag, ".dec"}, c(4'h0));
  endtask

  task automatic oper_imm(input string tag);
    cyc({tag, ".o0"}, c(4'h1));
    cyc({tag, ".o1"}, c(4'h0));
    cyc({tag, ".o2"}, v(4'h2, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic oper_dir(input string tag);
    oper_imm(tag);
    cyc({tag, ".o3"}, c(4'h4));
    cyc({tag, ".o4"}, c(4'h0));
    cyc({tag, ".o5"}, c(4'h2));
  endtask

  task automatic alu(input string tag, input logic [7:0] op, input logic has_oper, input logic ap);
    fetch(tag, op);
    if (has_oper) oper_imm(tag);
    cyc({tag, ".calc"}, v(4'h0, 1'b0, 2'b00, 1'b1, ap, 1'b0, 1'b0, 1'b0));
    cyc({tag, ".xr"},   v(4'hA, 1'b0, 2'b00, 1'b0, ap, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic hard_reset(input string tag);
    i_rstn = 1'b0;
    #1;
    check({tag, ".rst"}, 12'h000);
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
  endtask

  initial begin
    @(posedge i_clk);
    #1;
    cyc("reset", 12'h000);
    i_rstn = 1'b1;

    // NOP then HLT
    fetch("nop", 8'h00);
    cyc("nop.x", cr(4'h0));
    fetch("hlt", 8'hFF);
    cyc("hlt.x", cr(4'h0));
    cyc("halt0", v(4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    cyc("halt1", v(4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    hard_reset("halt");

    fetch("lda_i", 8'h11);  oper_imm("lda_i");  cyc("lda_i.x", cr(4'h5));
    fetch("lda_d", 8'h19);  oper_dir("lda_d");  cyc("lda_d.x", cr(4'h5));
    fetch("ldap_d", 8'h1B); oper_dir("ldap_d"); cyc("ldap_d.x", cr(4'h5));

    fetch("lda_ap", 8'h14);
    cyc("lda_ap.x0", c(4'h6));
    cyc("lda_ap.x1", c(4'h0));
    cyc("lda_ap.x2", c(4'h2));
    cyc("lda_ap.x3", cr(4'h5));

    fetch("sta", 8'h21);
    oper_imm("sta");
    cyc("sta.x0", c(4'h4));
    cyc("sta.x1", c(4'h8));
    cyc("sta.x2", cr(4'h9));

    fetch("push", 8'h2C);
    cyc("push.x0", c(4'h7));
    cyc("push.x1", c(4'h8));
    cyc("push.x2", v(4'h9, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));

    fetch("pop", 8'h1E);
    cyc("pop.x0", v(4'h0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("pop.x1", c(4'h7));
    cyc("pop.x2", c(4'h0));
    cyc("pop.x3", c(4'h2));
    cyc("pop.x4", cr(4'h5));

    alu("add_ap", 8'h38, 1'b1, 1'b1);
    alu("add_a",  8'h30, 1'b1, 1'b0);
    alu("sub_ap", 8'h48, 1'b1, 1'b1);
    alu("not",    8'h50, 1'b0, 1'b0);
    alu("shr8",   8'h98, 1'b0, 1'b0);
    alu("xor8",   8'h88, 1'b1, 1'b0);

    fetch("jz", 8'hA5);
    oper_imm("jz");
    cyc("jz.x", cr(4'hB));

    fetch("call", 8'hB0);
    cyc("call.x0", c(4'h7));
    cyc("call.x1", c(4'hF));
    cyc("call.x2", v(4'h9, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("call.x3", c(4'h1));
    cyc("call.x4", c(4'h0));
    cyc("call.x5", c(4'h2));
    cyc("call.x6", cr(4'hB));

    fetch("ret", 8'hC1);
    cyc("ret.x0", v(4'h0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("ret.x1", c(4'h7));
    cyc("ret.x2", c(4'h0));
    cyc("ret.x3", c(4'h2));
    cyc("ret.x4", c(4'h5));
    cyc("ret.x5", c(4'hE));
    cyc("ret.x6", v(4'h0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));

    fetch("in", 8'hD0);  cyc("in.x",  cr(4'hC));
    fetch("out", 8'hD1); cyc("out.x", cr(4'hD));

    fetch("ill", 8'hE5);
    cyc("ill.x", v(4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    fetch("after_ill", 8'h00);
    cyc("after_ill.x", cr(4'h0));

    // reset dropped in the middle of CALL
    fetch("call_rst", 8'hB0);
    cyc("call_rst.x0", c(4'h7));
    hard_reset("call_rst");
    fetch("refetch", 8'h00);
    cyc("refetch.x", cr(4'h0));
    fetch("hlt2", 8'hFF);
    cyc("hlt2.x", cr(4'h0));
    cyc("hlt2.halt", v(4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
